// File: rtl/aes_spi_pkg.sv
// aes_spi_pkg: shared types and constants for the AES SPI job scheduler
package aes_spi_pkg;
  localparam int DATA_W = 128;
  localparam logic ID_ENC = 1'b0;
  localparam logic ID_DEC = 1'b1;
  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, DONE} state_t;
endpackage

// File: rtl/aes_rr_arbiter.sv
// aes_rr_arbiter: two-way round-robin grant, ptr holds the last granted id (1 = decrypt)
module aes_rr_arbiter (
  input  logic       enc_valid,
  input  logic       dec_valid,
  input  logic       ptr,
  output logic [1:0] grant
);
  assign grant[0] = enc_valid & (~dec_valid | ptr);
  assign grant[1] = dec_valid & (~enc_valid | ~ptr);
endmodule

// File: rtl/aes_spi_scheduler.sv
// aes_spi_scheduler: arbitrates encrypt/decrypt jobs and runs each over SPI to its slave
module aes_spi_scheduler
  import aes_spi_pkg::*;
#(
  parameter int Nk = 4,
  parameter int WAIT_CYCLES = 0
) (
  input  logic               clk_master,
  input  logic               rst,
  input  logic               enc_valid,
  output logic               enc_ready,
  input  logic [DATA_W-1:0]  enc_data,
  input  logic [Nk*32-1:0]   enc_key,
  input  logic               dec_valid,
  output logic               dec_ready,
  input  logic [DATA_W-1:0]  dec_data,
  input  logic [Nk*32-1:0]   dec_key,
  input  logic               abort,
  output logic               res_valid,
  output logic               res_id,
  output logic [DATA_W-1:0]  res_data,
  output logic               busy,
  output logic               spi_mosi,
  input  logic               spi_miso,
  output logic               cs_enc_n,
  output logic               cs_dec_n
);
  localparam int SW = DATA_W + Nk * 32;
  state_t state;
  logic [SW-2:0] sr;
  logic [DATA_W-2:0] rx;
  logic owner;
  logic ptr;
  logic [15:0] cnt;
  logic [1:0] grant;
  logic acc_id;
  aes_rr_arbiter u_arb (
    .enc_valid(enc_valid),
    .dec_valid(dec_valid),
    .ptr(ptr),
    .grant(grant)
  );
  assign enc_ready = (state == IDLE) & grant[0];
  assign dec_ready = (state == IDLE) & grant[1];
  assign acc_id = dec_ready;
  assign busy = state != IDLE;
  // job sequencing: load, shift out, optional gap, shift in, publish result
  always_ff @(posedge clk_master or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      rx <= '0;
      owner <= ID_ENC;
      ptr <= ID_DEC;
      cnt <= '0;
      spi_mosi <= 1'b0;
      cs_enc_n <= 1'b1;
      cs_dec_n <= 1'b1;
      res_valid <= 1'b0;
      res_id <= ID_ENC;
      res_data <= '0;
    end else begin
      res_valid <= 1'b0;
      if (abort && (state == SEND || state == WAIT || state == RECV)) begin
        state <= IDLE;
        spi_mosi <= 1'b0;
        cs_enc_n <= 1'b1;
        cs_dec_n <= 1'b1;
      end else begin
        case (state)
          IDLE: if (enc_ready || dec_ready) begin
            sr <= acc_id ? {dec_data[DATA_W-2:0], dec_key} : {enc_data[DATA_W-2:0], enc_key};
            spi_mosi <= acc_id ? dec_data[DATA_W-1] : enc_data[DATA_W-1];
            owner <= acc_id;
            ptr <= acc_id;
            cs_enc_n <= acc_id;
            cs_dec_n <= ~acc_id;
            cnt <= '0;
            state <= SEND;
          end
          SEND: begin
            sr <= {sr[SW-3:0], 1'b0};
            cnt <= cnt + 16'd1;
            spi_mosi <= (cnt == 16'(SW - 1)) ? 1'b0 : sr[SW-2];
            if (cnt == 16'(SW - 1)) begin
              cnt <= '0;
              state <= (WAIT_CYCLES == 0) ? RECV : WAIT;
            end
          end
          WAIT: begin
            cnt <= cnt + 16'd1;
            if (cnt == 16'(WAIT_CYCLES - 1)) begin
              cnt <= '0;
              state <= RECV;
            end
          end
          RECV: begin
            rx <= {rx[DATA_W-3:0], spi_miso};
            cnt <= cnt + 16'd1;
            if (cnt == 16'(DATA_W - 1)) begin
              res_data <= {rx, spi_miso};
              res_valid <= 1'b1;
              res_id <= owner;
              cs_enc_n <= 1'b1;
              cs_dec_n <= 1'b1;
              state <= DONE;
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_aes_spi_scheduler.sv
// tb_aes_spi_scheduler: table-driven arbitration plus scoreboarded SPI slave for two configurations
module tb_aes_spi_scheduler;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  typedef struct {logic id; logic [127:0] d; logic [255:0] k; logic [127:0] r;} job_t;
  typedef struct {logic e; logic d; logic id;} vec_t;
  logic clk_master = 1'b0, rst = 1'b1, sel8 = 1'b0, ev = 1'b0, dv = 1'b0, abort = 1'b0, spi_miso = 1'b0;
  logic [127:0] enc_data = '0, dec_data = '0;
  logic [255:0] enc_key = '0, dec_key = '0;
  logic er4, dr4, rv4, rid4, busy4, mosi4, ce4, cd4, er8, dr8, rv8, rid8, busy8, mosi8, ce8, cd8;
  logic [127:0] rd4, rd8;
  logic o_er, o_dr, o_rv, o_rid, o_busy, o_mosi, o_ce, o_cd;
  logic [127:0] o_rd;
  int checks = 0, errors = 0, k = 0;
  logic [383:0] cap = '0;
  logic [127:0] resp = '0, last_res = '0;
  job_t sb[$];
  vec_t tbl[8];
  aes_spi_scheduler dut4 (
    .clk_master(clk_master), .rst(rst),
    .enc_valid(ev & ~sel8), .enc_ready(er4), .enc_data(enc_data), .enc_key(enc_key[127:0]),
    .dec_valid(dv & ~sel8), .dec_ready(dr4), .dec_data(dec_data), .dec_key(dec_key[127:0]),
    .abort(abort), .res_valid(rv4), .res_id(rid4), .res_data(rd4), .busy(busy4),
    .spi_mosi(mosi4), .spi_miso(spi_miso), .cs_enc_n(ce4), .cs_dec_n(cd4)
  );
  aes_spi_scheduler #(.Nk(8), .WAIT_CYCLES(3)) dut8 (
    .clk_master(clk_master), .rst(rst),
    .enc_valid(ev & sel8), .enc_ready(er8), .enc_data(enc_data), .enc_key(enc_key),
    .dec_valid(dv & sel8), .dec_ready(dr8), .dec_data(dec_data), .dec_key(dec_key),
    .abort(abort), .res_valid(rv8), .res_id(rid8), .res_data(rd8), .busy(busy8),
    .spi_mosi(mosi8), .spi_miso(spi_miso), .cs_enc_n(ce8), .cs_dec_n(cd8)
  );
  assign o_er = sel8 ? er8 : er4;
  assign o_dr = sel8 ? dr8 : dr4;
  assign o_rv = sel8 ? rv8 : rv4;
  assign o_rid = sel8 ? rid8 : rid4;
  assign o_rd = sel8 ? rd8 : rd4;
  assign o_busy = sel8 ? busy8 : busy4;
  assign o_mosi = sel8 ? mosi8 : mosi4;
  assign o_ce = sel8 ? ce8 : ce4;
  assign o_cd = sel8 ? cd8 : cd4;
  always #5 clk_master = ~clk_master;
  function automatic logic [127:0] resp_f(input logic [127:0] d, input logic [127:0] kk);
    return (d == PT) ? CT : (~d ^ kk);
  endfunction
  task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask
  // slave model and result monitor, sampled on the falling edge
  always @(negedge clk_master) begin
    int w, wt;
    job_t j;
    w = sel8 ? 384 : 256;
    wt = sel8 ? 3 : 0;
    if (o_rv) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_res got res_valid=1 expected no result");
      end else begin
        j = sb.pop_front();
        chk("res_id", 384'(o_rid), 384'(j.id));
        chk("res_data", 384'(o_rd), 384'(j.r));
        chk("latency", 384'(k + 1), 384'(w + wt + 129));
        last_res = j.r;
      end
    end
    if (o_ce & o_cd) begin
      k = 0;
      cap = '0;
      spi_miso = 1'b0;
    end else begin
      if (sb.size() > 0) chk("cs_other", 384'(sb[0].id ? o_ce : o_cd), 384'(1));
      if (k < w) cap = {cap[382:0], o_mosi};
      if (k == w - 1) begin
        resp = resp_f(sel8 ? cap[383:256] : cap[255:128], cap[127:0]);
        if (sb.size() > 0) chk("mosi_stream", cap, sel8 ? {sb[0].d, sb[0].k} : {128'b0, sb[0].d, sb[0].k[127:0]});
      end
      if (k >= w && k < w + wt) chk("wait_mosi", 384'(o_mosi), 384'(0));
      spi_miso = (k >= w + wt && k < w + wt + 128) ? resp[127 - (k - w - wt)] : 1'b0;
      k++;
    end
  end
  task automatic run_job(input logic e, input logic d, input logic exp_id);
    job_t j;
    @(posedge clk_master);
    #1;
    ev = e;
    dv = d;
    @(negedge clk_master);
    chk("grant", 384'({o_er, o_dr}), exp_id ? 384'(2'b01) : 384'(2'b10));
    j.id = exp_id;
    j.d = exp_id ? dec_data : enc_data;
    j.k = exp_id ? dec_key : enc_key;
    j.r = resp_f(j.d, j.k[127:0]);
    sb.push_back(j);
    @(posedge clk_master);
    #1;
    ev = 1'b0;
    dv = 1'b0;
    chk("busy", 384'(o_busy), 384'(1));
  endtask
  task automatic wait_done(input int lim);
    int n;
    n = 0;
    while (sb.size() > 0 && n < lim) begin
      @(negedge clk_master);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL timeout got no result within %0d cycles expected res_valid", lim);
      sb.delete();
    end
  endtask
  task automatic rand_data();
    enc_data = {$urandom, $urandom, $urandom, $urandom};
    dec_data = {$urandom, $urandom, $urandom, $urandom};
    enc_key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    dec_key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog got no end of test expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl = '{'{1'b1, 1'b0, 1'b0}, '{1'b1, 1'b1, 1'b1}, '{1'b1, 1'b1, 1'b0}, '{1'b1, 1'b1, 1'b1},
            '{1'b0, 1'b1, 1'b1}, '{1'b1, 1'b1, 1'b0}, '{1'b1, 1'b0, 1'b0}, '{1'b1, 1'b1, 1'b1}};
    repeat (3) @(negedge clk_master);
    chk("rst_cs_enc", 384'(o_ce), 384'(1));
    chk("rst_cs_dec", 384'(o_cd), 384'(1));
    chk("rst_mosi", 384'(o_mosi), 384'(0));
    chk("rst_res_valid", 384'(o_rv), 384'(0));
    chk("rst_res_id", 384'(o_rid), 384'(0));
    chk("rst_res_data", 384'(o_rd), 384'(0));
    chk("rst_busy", 384'(o_busy), 384'(0));
    @(posedge clk_master);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rand_data();
      if (i == 0) begin
        enc_data = PT;
        enc_key = {128'b0, KEY};
      end
      run_job(tbl[i].e, tbl[i].d, tbl[i].id);
      if (i == 2) begin
        repeat (5) @(posedge clk_master);
        #1 dv = 1'b1;
        ev = 1'b1;
        @(negedge clk_master);
        chk("ready_while_busy", 384'({o_er, o_dr}), 384'(2'b00));
        @(posedge clk_master);
        #1 dv = 1'b0;
        ev = 1'b0;
      end
      wait_done(600);
      repeat (3) @(negedge clk_master);
      chk("res_hold", 384'(o_rd), 384'(last_res));
      chk("idle_busy", 384'(o_busy), 384'(0));
    end
    rand_data();
    run_job(1'b1, 1'b1, 1'b0);
    repeat (99) @(posedge clk_master);
    #1 abort = 1'b1;
    sb.delete();
    @(posedge clk_master);
    #1 abort = 1'b0;
    @(negedge clk_master);
    chk("abort_cs_enc", 384'(o_ce), 384'(1));
    chk("abort_cs_dec", 384'(o_cd), 384'(1));
    chk("abort_busy", 384'(o_busy), 384'(0));
    chk("abort_mosi", 384'(o_mosi), 384'(0));
    repeat (400) @(negedge clk_master);
    rand_data();
    run_job(1'b1, 1'b1, 1'b1);
    wait_done(600);
    rand_data();
    run_job(1'b1, 1'b0, 1'b0);
    repeat (306) @(posedge clk_master);
    #3 rst = 1'b1;
    sb.delete();
    #1;
    chk("arst_cs_enc", 384'(o_ce), 384'(1));
    chk("arst_cs_dec", 384'(o_cd), 384'(1));
    chk("arst_mosi", 384'(o_mosi), 384'(0));
    chk("arst_res_valid", 384'(o_rv), 384'(0));
    chk("arst_res_id", 384'(o_rid), 384'(0));
    chk("arst_res_data", 384'(o_rd), 384'(0));
    chk("arst_busy", 384'(o_busy), 384'(0));
    @(posedge clk_master);
    #1 rst = 1'b0;
    rand_data();
    run_job(1'b1, 1'b1, 1'b0);
    wait_done(600);
    @(posedge clk_master);
    #1 sel8 = 1'b1;
    rand_data();
    run_job(1'b1, 1'b0, 1'b0);
    wait_done(800);
    repeat (3) @(negedge clk_master);
    chk("nk8_res_hold", 384'(o_rd), 384'(last_res));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
